// File: rtl/ifetch32_hs.sv
// Instruction-fetch stage for the single-cycle MIPS core: PC, imem req/ready handshake, next-PC select, retire strobe.
// Optional misaligned-jr redirect to EXC_VECTOR is built when IFETCH_ALIGN_EXC_EN is defined.
//   state | meaning
//   FETCH | imem_req high, waiting for imem_ready to latch the instruction word
//   EXEC  | Instruction valid to decode; retires (and advances pc) when not stalled
module ifetch32_hs #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_AW    = 14,
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        Instruction,
    output logic               instr_valid,
    input  logic               stall,
    output logic               retire,
    output logic [31:0]        pc,
    output logic [31:0]        link_addr,
    input  logic [31:0]        Addr_Result,
    input  logic [31:0]        Read_data_1,
    input  logic               Branch,
    input  logic               nBranch,
    input  logic               Zero,
    input  logic               Jmp,
    input  logic               Jal,
    input  logic               Jr,
    output logic               fetch_err,
    output logic [31:0]        retired_cnt,
    output logic               exc_pulse
);

    typedef enum logic {FETCH, EXEC} state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_t      state;
    state_t      state_nx;
    logic        latch_instr;
    logic [31:0] next_pc;
    logic [31:0] jump_target;
    logic        take_branch;
    logic [15:0] wait_cnt;
    logic [15:0] wait_inc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nx;
        end
    end

    // Handshake outputs are masked while reset is high so no request leaks out of the reset cycle.
    always_comb begin
        state_nx    = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        retire      = 1'b0;
        latch_instr = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        latch_instr = 1'b1;
                        state_nx    = EXEC;
                    end
                end
                EXEC: begin
                    instr_valid = 1'b1;
                    if (!stall) begin
                        retire   = 1'b1;
                        state_nx = FETCH;
                    end
                end
                default: state_nx = FETCH;
            endcase
        end
    end

    assign imem_addr = pc[IMEM_AW+1:2];
    assign link_addr = pc + 32'd4;
    assign wait_inc  = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

    always_comb begin
        jump_target = {link_addr[31:28], Instruction[25:0], 2'b00};
        take_branch = (Branch & Zero) | (nBranch & ~Zero);
        if (Jr) begin
            next_pc = Read_data_1;
        end else if (Jmp | Jal) begin
            next_pc = jump_target;
        end else if (take_branch) begin
            next_pc = Addr_Result;
        end else begin
            next_pc = link_addr;
        end
`ifdef IFETCH_ALIGN_EXC_EN
        if (Jr && (Read_data_1[1:0] != 2'b00)) begin
            next_pc = EXC_VECTOR;
        end
`endif
    end

`ifdef IFETCH_ALIGN_EXC_EN
    assign exc_pulse = retire & Jr & (Read_data_1[1:0] != 2'b00);
`else
    assign exc_pulse = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= RESET_PC;
            Instruction <= 32'h0;
            retired_cnt <= 32'h0;
            fetch_err   <= 1'b0;
            wait_cnt    <= 16'h0;
        end else begin
            if (latch_instr) begin
                Instruction <= imem_rdata;
            end
            if (retire) begin
                pc          <= next_pc;
                retired_cnt <= retired_cnt + 32'd1;
            end
            // fetch_err is sticky; the request keeps waiting after it is raised.
            if (imem_req) begin
                if (imem_ready) begin
                    wait_cnt <= 16'h0;
                end else begin
                    wait_cnt <= wait_inc;
                    if (wait_inc >= TIMEOUT_W) begin
                        fetch_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch32_hs.sv
// Directed self-checking bench for ifetch32_hs: reset, branches, jumps, wrap, stall, timeout, misaligned jr.
module tb_ifetch32_hs;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [13:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic        instr_valid;
    logic        stall;
    logic        retire;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic [31:0] Addr_Result;
    logic [31:0] Read_data_1;
    logic        Branch, nBranch, Zero, Jmp, Jal, Jr;
    logic        fetch_err;
    logic [31:0] retired_cnt;
    logic        exc_pulse;

    logic [31:0] mem [0:255];
    int          passed = 0;
    int          total  = 0;
    logic [31:0] exp_ret = 32'h0;

    ifetch32_hs dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .Instruction(Instruction), .instr_valid(instr_valid), .stall(stall), .retire(retire),
        .pc(pc), .link_addr(link_addr), .Addr_Result(Addr_Result), .Read_data_1(Read_data_1),
        .Branch(Branch), .nBranch(nBranch), .Zero(Zero), .Jmp(Jmp), .Jal(Jal), .Jr(Jr),
        .fetch_err(fetch_err), .retired_cnt(retired_cnt), .exc_pulse(exc_pulse)
    );

    always #5 clock = ~clock;

    assign imem_rdata = mem[imem_addr[7:0]];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctl();
        Branch = 0; nBranch = 0; Zero = 0; Jmp = 0; Jal = 0; Jr = 0;
        Addr_Result = 32'h0; Read_data_1 = 32'h0; stall = 0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 40) begin
            step();
            n++;
        end
        if (!instr_valid) begin
            total++;
            $display("FAIL wait_valid: instr_valid=%b after %0d cycles, want 1", instr_valid, n);
        end
    endtask

    task automatic retire_step();
        step();
        exp_ret = exp_ret + 32'd1;
    endtask

    task automatic test_reset();
        reset = 1; imem_ready = 1;
        step(); step();
        total++; if (pc !== 32'h0) $display("FAIL rst_pc: got %h want %h", pc, 32'h0); else passed++;
        total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else passed++;
        total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", instr_valid); else passed++;
        total++; if (Instruction !== 32'h0) $display("FAIL rst_instr: got %h want 0", Instruction); else passed++;
        total++; if (retired_cnt !== 32'h0) $display("FAIL rst_cnt: got %h want 0", retired_cnt); else passed++;
        total++; if (fetch_err !== 1'b0) $display("FAIL rst_err: got %b want 0", fetch_err); else passed++;
        reset = 0;
        #1;
        total++; if (imem_req !== 1'b1) $display("FAIL first_req: got %b want 1", imem_req); else passed++;
        total++; if (imem_addr !== 14'h0) $display("FAIL first_addr: got %h want 0", imem_addr); else passed++;
        step();
        total++; if (instr_valid !== 1'b1) $display("FAIL fetch_valid: got %b want 1", instr_valid); else passed++;
        total++; if (Instruction !== 32'h2008_0005) $display("FAIL fetch_instr: got %h want %h", Instruction, 32'h2008_0005); else passed++;
        total++; if (retire !== 1'b1) $display("FAIL fetch_retire: got %b want 1", retire); else passed++;
        total++; if (link_addr !== 32'h4) $display("FAIL fetch_link: got %h want 4", link_addr); else passed++;
        retire_step();
        total++; if (pc !== 32'h4) $display("FAIL seq_pc: got %h want 4", pc); else passed++;
        total++; if (link_addr !== 32'h8) $display("FAIL seq_link: got %h want 8", link_addr); else passed++;
        total++; if (retired_cnt !== exp_ret) $display("FAIL seq_cnt: got %h want %h", retired_cnt, exp_ret); else passed++;
        total++; if (instr_valid !== 1'b0) $display("FAIL seq_valid: got %b want 0", instr_valid); else passed++;
    endtask

    task automatic test_branch();
        Branch = 1; Zero = 1; Addr_Result = 32'h40;
        wait_valid(); retire_step();
        total++; if (pc !== 32'h40) $display("FAIL beq_taken: got %h want 40", pc); else passed++;
        Zero = 0;
        wait_valid(); retire_step();
        total++; if (pc !== 32'h44) $display("FAIL beq_not: got %h want 44", pc); else passed++;
        Branch = 0; nBranch = 1; Zero = 0;
        wait_valid(); retire_step();
        total++; if (pc !== 32'h40) $display("FAIL bne_taken: got %h want 40", pc); else passed++;
        Branch = 1; nBranch = 1; Zero = 1; Addr_Result = 32'h80;
        wait_valid(); retire_step();
        total++; if (pc !== 32'h80) $display("FAIL both_br: got %h want 80", pc); else passed++;
        Branch = 0; nBranch = 1; Zero = 1;
        wait_valid(); retire_step();
        total++; if (pc !== 32'h84) $display("FAIL bne_not: got %h want 84", pc); else passed++;
        clear_ctl();
    endtask

    task automatic test_jump();
        Jr = 1; Read_data_1 = 32'h100;
        wait_valid(); retire_step();
        total++; if (pc !== 32'h100) $display("FAIL jr: got %h want 100", pc); else passed++;
        clear_ctl(); Jal = 1;
        wait_valid();
        total++; if (Instruction !== 32'h0C00_0010) $display("FAIL jal_instr: got %h want %h", Instruction, 32'h0C00_0010); else passed++;
        total++; if (link_addr !== 32'h104) $display("FAIL jal_link: got %h want 104", link_addr); else passed++;
        retire_step();
        total++; if (pc !== 32'h40) $display("FAIL jal_pc: got %h want 40", pc); else passed++;
        clear_ctl(); Jr = 1; Jmp = 1; Read_data_1 = 32'h200;
        wait_valid(); retire_step();
        total++; if (pc !== 32'h200) $display("FAIL jr_over_j: got %h want 200", pc); else passed++;
        clear_ctl();
    endtask

    task automatic test_wrap();
        Jr = 1; Read_data_1 = 32'hFFFF_FFFC;
        wait_valid(); retire_step();
        clear_ctl();
        wait_valid();
        total++; if (link_addr !== 32'h0) $display("FAIL link_wrap: got %h want 0", link_addr); else passed++;
        retire_step();
        total++; if (pc !== 32'h0) $display("FAIL pc_wrap: got %h want 0", pc); else passed++;
        Jr = 1; Read_data_1 = 32'h200;
        wait_valid(); retire_step();
        clear_ctl();
    endtask

    task automatic test_stall();
        stall = 1;
        wait_valid();
        for (int i = 0; i < 3; i++) begin
            total++; if (retire !== 1'b0) $display("FAIL stall_retire[%0d]: got %b want 0", i, retire); else passed++;
            total++; if (pc !== 32'h200) $display("FAIL stall_pc[%0d]: got %h want 200", i, pc); else passed++;
            total++; if (Instruction !== 32'hDEAD_BEEF) $display("FAIL stall_instr[%0d]: got %h want deadbeef", i, Instruction); else passed++;
            total++; if (retired_cnt !== exp_ret) $display("FAIL stall_cnt[%0d]: got %h want %h", i, retired_cnt, exp_ret); else passed++;
            step();
        end
        stall = 0;
        #1;
        total++; if (retire !== 1'b1) $display("FAIL release_retire: got %b want 1", retire); else passed++;
        retire_step();
        total++; if (pc !== 32'h204) $display("FAIL release_pc: got %h want 204", pc); else passed++;
        total++; if (retired_cnt !== exp_ret) $display("FAIL release_cnt: got %h want %h", retired_cnt, exp_ret); else passed++;
        stall = 1;
        step();
        total++; if (instr_valid !== 1'b1) $display("FAIL stall_in_fetch: got %b want 1", instr_valid); else passed++;
        stall = 0;
        retire_step();
    endtask

    task automatic test_timeout();
        imem_ready = 0;
        for (int i = 0; i < 15; i++) step();
        total++; if (fetch_err !== 1'b0) $display("FAIL err_early: got %b want 0", fetch_err); else passed++;
        step();
        total++; if (fetch_err !== 1'b1) $display("FAIL err_set: got %b want 1", fetch_err); else passed++;
        total++; if (imem_req !== 1'b1) $display("FAIL err_req: got %b want 1", imem_req); else passed++;
        imem_ready = 1;
        wait_valid(); retire_step();
        total++; if (fetch_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", fetch_err); else passed++;
        total++; if (pc !== 32'h20C) $display("FAIL err_pc: got %h want 20c", pc); else passed++;
        imem_ready = 0;
        step(); step(); step();
        reset = 1;
        step();
        reset = 0; exp_ret = 32'h0;
        #1;
        total++; if (fetch_err !== 1'b0) $display("FAIL err_clear: got %b want 0", fetch_err); else passed++;
        total++; if (pc !== 32'h0) $display("FAIL abandon_pc: got %h want 0", pc); else passed++;
        total++; if (Instruction !== 32'h0) $display("FAIL abandon_instr: got %h want 0", Instruction); else passed++;
        total++; if (instr_valid !== 1'b0) $display("FAIL abandon_valid: got %b want 0", instr_valid); else passed++;
        imem_ready = 1;
        wait_valid();
        total++; if (Instruction !== 32'h2008_0005) $display("FAIL refetch: got %h want %h", Instruction, 32'h2008_0005); else passed++;
        retire_step();
        total++; if (pc !== 32'h4) $display("FAIL refetch_pc: got %h want 4", pc); else passed++;
    endtask

    task automatic test_misaligned();
        logic [31:0] want_pc;
        logic        want_exc;
`ifdef IFETCH_ALIGN_EXC_EN
        want_pc = 32'h180; want_exc = 1'b1;
`else
        want_pc = 32'h202; want_exc = 1'b0;
`endif
        Jr = 1; Read_data_1 = 32'h202;
        wait_valid();
        total++; if (exc_pulse !== want_exc) $display("FAIL exc_pulse: got %b want %b", exc_pulse, want_exc); else passed++;
        retire_step();
        clear_ctl();
        total++; if (pc !== want_pc) $display("FAIL jr_misalign_pc: got %h want %h", pc, want_pc); else passed++;
        total++; if (exc_pulse !== 1'b0) $display("FAIL exc_oneshot: got %b want 0", exc_pulse); else passed++;
        total++; if (imem_addr !== want_pc[15:2]) $display("FAIL misalign_addr: got %h want %h", imem_addr, want_pc[15:2]); else passed++;
        total++; if (retired_cnt !== exp_ret) $display("FAIL final_cnt: got %h want %h", retired_cnt, exp_ret); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h00] = 32'h2008_0005;
        mem[8'h40] = 32'h0C00_0010;
        mem[8'h80] = 32'hDEAD_BEEF;
        clear_ctl();
        reset = 1; imem_ready = 1;
        test_reset();
        test_branch();
        test_jump();
        test_wrap();
        test_stall();
        test_timeout();
        test_misaligned();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
